fifo_uart_tx: RTL and testbench

- Reader-side companion to the team's 16x8 synchronous FIFO.
- Drains bytes from the FIFO read port (re/empty/data) one at a time and serialises each byte as a UART 8N1 frame on a single tx line.
- Sits between the FIFO and the board serial pin; a producer fills the FIFO and this block empties it at line rate.

---
 rtl/fifo_uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/fifo_uart_tx.sv | 102 ++++++++++
 tb/tb_fifo_uart_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  // Width of a counter that spans 0..clks-1, never narrower than one bit.
  function automatic int cnt_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wraps on its own at each bit boundary so consecutive bits need no help from the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a registered-output FIFO and sends each one as a UART 8N1 frame.
//
// state | meaning
// IDLE  | line idle, waiting for en=1 and a non-empty FIFO
// REQ   | re strobe to the FIFO (one cycle)
// LOAD  | FIFO data valid; captured into the shift register
// START | start bit (tx=0)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1); decides between back-to-back fetch and IDLE
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              re,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              bit_end;
  logic              clr;

  assign clr = (state == IDLE) || (state == REQ) || (state == LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .bit_end(bit_end)
  );

  assign re         = (state == REQ);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end;

  // tx always carries the bit now on the line; the shift register's LSB holds the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (en && !empty) state <= REQ;
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg <= fifo_data;
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) state <= (en && !empty) ? REQ : IDLE;
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx fed from a behavioural 16x8 registered-read FIFO.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       empty;
  logic [7:0] fifo_data;
  logic       re;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic       wr;
  logic [7:0] wd;
  logic [7:0] mem [16];
  int         wp = 0;
  int         rp = 0;
  int         fcnt = 0;

  int errors = 0;
  int checks = 0;
  int re_cnt = 0;
  logic prev_re = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .empty     (empty),
    .fifo_data (fifo_data),
    .re        (re),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after re.
  assign empty = (fcnt == 0);
  always @(posedge clk) begin
    automatic int rd = (re === 1'b1 && fcnt > 0) ? 1 : 0;
    if (rd == 1) begin
      fifo_data <= mem[rp];
      rp <= (rp + 1) % 16;
    end
    if (wr === 1'b1) begin
      mem[wp] <= wd;
      wp <= (wp + 1) % 16;
    end
    fcnt <= fcnt + ((wr === 1'b1) ? 1 : 0) - rd;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (re === 1'b1) begin
      re_cnt++;
      chk("re_single_cycle", {31'd0, prev_re}, 32'd0);
      chk("re_while_empty", {31'd0, empty}, 32'd0);
    end
    prev_re = re;
  end

  task automatic push(input logic [7:0] b);
    wd = b;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_start(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
    chk("start_seen", {31'd0, ok}, 32'd1);
  endtask

  // j=0 is the first negedge of the start bit; the frame spans 10*CPB cycles.
  task automatic frame_body(input logic [7:0] b, input int drop_j, input int abort_j,
                            input string tag);
    logic e;
    for (int j = 0; j < 10 * CPB; j++) begin
      if (j > 0) @(negedge clk);
      if (j == abort_j) return;
      if (j < CPB) e = 1'b0;
      else if (j < 9 * CPB) e = b[(j - CPB) / CPB];
      else e = 1'b1;
      chk({tag, "_tx"}, {31'd0, tx}, {31'd0, e});
      chk({tag, "_frame_done"}, {31'd0, frame_done}, (j == 10 * CPB - 1) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (j == drop_j) en = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input string tag, output int gap);
    bit ok;
    wait_start(gap, ok);
    if (ok) frame_body(b, -1, -1, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    int viol;
    int base;
    bit ok;

    rst_n = 1'b1;
    en    = 1'b0;
    wr    = 1'b0;
    wd    = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_re", {31'd0, re}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty FIFO with en high: nothing happens.
    en = 1'b1;
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("empty_idle_violations", viol, 0);
    chk("empty_idle_re_cnt", re_cnt, 0);
    en = 1'b0;

    // Single byte 0xA5.
    @(negedge clk);
    push(8'hA5);
    en = 1'b1;
    frame(8'hA5, "a5", gap);
    chk("a5_latency_gap", gap, 2);
    @(negedge clk);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_re_cnt", re_cnt, 1);

    // Back-to-back 0x00, 0xFF, 0x3C.
    en = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    en = 1'b1;
    frame(8'h00, "b00", gap);
    frame(8'hFF, "bff", gap);
    chk("bff_gap", gap, 2);
    frame(8'h3C, "b3c", gap);
    chk("b3c_gap", gap, 2);
    @(negedge clk);
    chk("b2b_busy_after", {31'd0, busy}, 32'd0);
    chk("b2b_re_cnt", re_cnt, 4);

    // en dropped during data bit 3 of 0x5A while 0x77 waits.
    en = 1'b0;
    push(8'h5A);
    push(8'h77);
    en = 1'b1;
    wait_start(gap, ok);
    if (ok) frame_body(8'h5A, 4 * CPB + 1, -1, "s5a");
    repeat (20) @(negedge clk);
    chk("en_low_re_cnt", re_cnt, 5);
    chk("en_low_busy", {31'd0, busy}, 32'd0);
    chk("en_low_tx", {31'd0, tx}, 32'd1);
    en = 1'b1;
    frame(8'h77, "s77", gap);
    @(negedge clk);
    chk("s77_re_cnt", re_cnt, 6);

    // Reset during data bit 5 of 0xC3; 0x96 follows after release.
    en = 1'b0;
    push(8'hC3);
    push(8'h96);
    en = 1'b1;
    wait_start(gap, ok);
    if (ok) frame_body(8'hC3, -1, 6 * CPB + 2, "sc3");
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_re", {31'd0, re}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(8'h96, "s96", gap);
    chk("s96_latency_gap", gap, 2);
    @(negedge clk);
    chk("s96_re_cnt", re_cnt, 8);

    // Fill FIFO with 0x10..0x1F and drain it.
    en = 1'b0;
    base = re_cnt;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      frame(8'(8'h10 + i), $sformatf("f%0d", i), gap);
      if (i > 0) chk($sformatf("f%0d_gap", i), gap, 2);
    end
    @(negedge clk);
    chk("fill_re_cnt", re_cnt - base, 16);
    chk("fill_empty", {31'd0, empty}, 32'd1);
    chk("fill_busy_after", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
